// File: rtl/register_history_bank.sv
// WIDTH x DEPTH history shift register: a qualified load pushes D into entry 0
// and ages older entries; a tap select reads any entry onto a tri-state Q bus.
// Ports:
//   Clock, Reset (sync, active-high), ClockEnable & Tick qualify a load of D.
//   pre presets all entries to ones; cs=1 floats Q; Sel picks the tap
//   (0 = newest).
//   Q and Valid give the tap word and its validity. Fill and Full give the
//   fill level.
//   Evicted/EvictStrobe report the word pushed out of the last entry.
// Optional feature macro: HIST_CHANGE_DETECT_EN adds registered output Changed.
module register_history_bank #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SEL_BITS  = 2,
  parameter int FILL_BITS = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ClockEnable,
  input  logic                 Tick,
  input  logic [WIDTH-1:0]     D,
  input  logic                 pre,
  input  logic                 cs,
  input  logic [SEL_BITS-1:0]  Sel,
  output logic [WIDTH-1:0]     Q,
  output logic                 Valid,
  output logic [FILL_BITS-1:0] Fill,
  output logic                 Full,
  output logic [WIDTH-1:0]     Evicted,
  output logic                 EvictStrobe
`ifdef HIST_CHANGE_DETECT_EN
  ,
  output logic                 Changed
`endif
);

  localparam logic [FILL_BITS-1:0] FILL_MAX = FILL_BITS'(DEPTH);

  logic [WIDTH-1:0]     ent_q [DEPTH];
  logic [WIDTH-1:0]     ent_d [DEPTH];
  logic [FILL_BITS-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]     evicted_q, evicted_d;
  logic                 evict_stb_q, evict_stb_d;
  logic                 full;
  logic                 load;
  logic [WIDTH-1:0]     rd_word;

  assign load = ClockEnable & Tick;
  assign full = (fill_q == FILL_MAX);

`ifdef HIST_CHANGE_DETECT_EN
  logic changed_q, changed_d;
`endif

  always_comb begin
    ent_d       = ent_q;
    fill_d      = fill_q;
    evicted_d   = evicted_q;
    evict_stb_d = 1'b0;
`ifdef HIST_CHANGE_DETECT_EN
    changed_d   = changed_q;
`endif
    if (pre) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '1;
      fill_d = FILL_MAX;
`ifdef HIST_CHANGE_DETECT_EN
      changed_d = 1'b0;
`endif
    end else if (load) begin
      ent_d[0] = D;
      for (int i = 1; i < DEPTH; i++) ent_d[i] = ent_q[i-1];
      fill_d = full ? fill_q : fill_q + 1'b1;
      // Only a full history actually drops a word off the far end.
      if (full) begin
        evicted_d   = ent_q[DEPTH-1];
        evict_stb_d = 1'b1;
      end
`ifdef HIST_CHANGE_DETECT_EN
      changed_d = (fill_q == '0) || (D != ent_q[0]);
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      fill_q      <= '0;
      evicted_q   <= '0;
      evict_stb_q <= 1'b0;
`ifdef HIST_CHANGE_DETECT_EN
      changed_q   <= 1'b0;
`endif
    end else begin
      ent_q       <= ent_d;
      fill_q      <= fill_d;
      evicted_q   <= evicted_d;
      evict_stb_q <= evict_stb_d;
`ifdef HIST_CHANGE_DETECT_EN
      changed_q   <= changed_d;
`endif
    end
  end

  // Taps beyond DEPTH (non-power-of-two DEPTH) read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(Sel) == i) rd_word = ent_q[i];
    end
  end

  assign Q           = cs ? {WIDTH{1'bz}} : rd_word;
  assign Valid       = (32'(Sel) < 32'(fill_q));
  assign Fill        = fill_q;
  assign Full        = full;
  assign Evicted     = evicted_q;
  assign EvictStrobe = evict_stb_q;
`ifdef HIST_CHANGE_DETECT_EN
  assign Changed     = changed_q;
`endif

endmodule
